// File: rtl/control_rotativo_if.sv
// Commit bus between the rotary sequencer and the configuration register file.
// The sequencer drives the request side and the register file returns the acknowledge.
interface control_rotativo_if #(
  parameter int WIDTH = 8
);
  logic             WR_VALID;
  logic [1:0]       WR_ADDR;
  logic [WIDTH-1:0] WR_DATA;
  logic             WR_ACK;

  modport master (output WR_VALID, output WR_ADDR, output WR_DATA, input WR_ACK);
  modport slave  (input WR_VALID, input WR_ADDR, input WR_DATA, output WR_ACK);
endinterface

// File: rtl/control_rotativo.sv
// Rotary encoder sequencer: four saturating setting registers with velocity-dependent steps,
// committed downstream over a valid/acknowledge bus after a button press or an idle timeout.
module control_rotativo #(
  parameter int WIDTH     = 8,
  parameter int VMIN      = 0,
  parameter int VMAX      = 255,
  parameter int STEP_SLOW = 1,
  parameter int STEP_FAST = 8,
  parameter int FAST_WIN  = 250000,
  parameter int IDLE_TO   = 25000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EV,
  input  logic             IZ,
  input  logic             PB,
  output logic [1:0]       SEL,
  output logic [WIDTH-1:0] VAL,
  output logic             DIRTY,
  control_rotativo_if.master wr
);

  typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_COMMIT} state_t;

  localparam logic [WIDTH:0]   VMAX_X      = (WIDTH+1)'(VMAX);
  localparam logic [WIDTH:0]   VMIN_X      = (WIDTH+1)'(VMIN);
  localparam logic [WIDTH-1:0] VMAX_W      = WIDTH'(VMAX);
  localparam logic [WIDTH-1:0] VMIN_W      = WIDTH'(VMIN);
  localparam logic [WIDTH:0]   STEP_SLOW_X = (WIDTH+1)'(STEP_SLOW);
  localparam logic [WIDTH:0]   STEP_FAST_X = (WIDTH+1)'(STEP_FAST);
  localparam logic [25:0]      FAST_WIN_T  = 26'(FAST_WIN);
  localparam logic [25:0]      IDLE_LAST   = 26'(IDLE_TO - 1);
  localparam logic [25:0]      GAP_MAX     = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             dirty_q, dirty_d;
  logic             wr_valid_q, wr_valid_d;
  logic [1:0]       wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [25:0]      gap_q, gap_d;
  logic [25:0]      idle_q, idle_d;

  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   floor_sum;
  logic [WIDTH-1:0] stepped;
  logic             commit_go;

  // Saturating step, evaluated one bit wider than the register so nothing wraps.
  always_comb begin
    cur       = regs_q[sel_q];
    step      = (gap_q < FAST_WIN_T) ? STEP_FAST_X : STEP_SLOW_X;
    sum       = {1'b0, cur} + step;
    floor_sum = VMIN_X + step;
    if (IZ) begin
      stepped = ({1'b0, cur} < floor_sum) ? VMIN_W : (cur - step[WIDTH-1:0]);
    end else begin
      stepped = (sum > VMAX_X) ? VMAX_W : sum[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    sel_d      = sel_q;
    dirty_d    = dirty_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    idle_d     = idle_q;
    commit_go  = 1'b0;

    if (EV && state_q != ST_COMMIT) begin
      gap_d = '0;
    end else begin
      gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + 26'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (EV) begin
          regs_d[sel_q] = stepped;
          dirty_d       = 1'b1;
          idle_d        = '0;
          state_d       = ST_EDIT;
        end else if (PB) begin
          sel_d = sel_q + 2'd1;
        end
      end
      ST_EDIT: begin
        if (EV) begin
          regs_d[sel_q] = stepped;
          idle_d        = '0;
          commit_go     = PB;
        end else if (PB || idle_q == IDLE_LAST) begin
          commit_go = 1'b1;
        end else begin
          idle_d = idle_q + 26'd1;
        end
        if (commit_go) begin
          // The committed data includes a step taken on the same edge as the button.
          state_d    = ST_COMMIT;
          wr_valid_d = 1'b1;
          wr_addr_d  = sel_q;
          wr_data_d  = EV ? stepped : cur;
        end
      end
      ST_COMMIT: begin
        if (wr.WR_ACK) begin
          wr_valid_d = 1'b0;
          dirty_d    = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    val_d = regs_d[sel_d];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_regs
    always_ff @(posedge CLK) begin
      if (RST) begin
        regs_q[gi] <= VMIN_W;
      end else begin
        regs_q[gi] <= regs_d[gi];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      val_q      <= VMIN_W;
      dirty_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      gap_q      <= GAP_MAX;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      dirty_q    <= dirty_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      gap_q      <= gap_d;
      idle_q     <= idle_d;
    end
  end

  assign SEL         = sel_q;
  assign VAL         = val_q;
  assign DIRTY       = dirty_q;
  assign wr.WR_VALID = wr_valid_q;
  assign wr.WR_ADDR  = wr_addr_q;
  assign wr.WR_DATA  = wr_data_q;

endmodule

// File: tb/tb_control_rotativo.sv
// Bench for control_rotativo: directed scenarios plus a randomized run, all checked
// against an event-time reference model of the rotary sequencer.
module tb_control_rotativo;

  localparam int W     = 8;
  localparam int VMIN  = 10;
  localparam int VMAX  = 50;
  localparam int SSLOW = 1;
  localparam int SFAST = 8;
  localparam int FWIN  = 4;
  localparam int ITO   = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         EV  = 1'b0;
  logic         IZ  = 1'b0;
  logic         PB  = 1'b0;
  logic [1:0]   SEL;
  logic [W-1:0] VAL;
  logic         DIRTY;

  control_rotativo_if #(.WIDTH(W)) bus ();

  control_rotativo #(
    .WIDTH(W), .VMIN(VMIN), .VMAX(VMAX), .STEP_SLOW(SSLOW),
    .STEP_FAST(SFAST), .FAST_WIN(FWIN), .IDLE_TO(ITO)
  ) dut (
    .CLK(CLK), .RST(RST), .EV(EV), .IZ(IZ), .PB(PB),
    .SEL(SEL), .VAL(VAL), .DIRTY(DIRTY), .wr(bus)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: values, selection, and event times measured in clock edges.
  int m_reg [4];
  int m_sel, m_dirty, m_wv, m_wa, m_wd;
  int m_editing, m_have_ev, m_last_ev;
  int edge_no = 0;

  task automatic model_edge(input logic rst, ev, iz, pb, ack);
    int nv, step;
    bit fire;
    edge_no++;
    fire = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = VMIN;
      m_sel = 0; m_dirty = 0; m_wv = 0; m_wa = 0; m_wd = 0;
      m_editing = 0; m_have_ev = 0; m_last_ev = 0;
    end else if (m_wv != 0) begin
      if (ack) begin
        m_wv = 0; m_dirty = 0; m_editing = 0;
      end
    end else begin
      if (ev) begin
        step = (m_have_ev != 0 && (edge_no - m_last_ev) <= FWIN) ? SFAST : SSLOW;
        nv   = iz ? m_reg[m_sel] - step : m_reg[m_sel] + step;
        if (nv > VMAX) nv = VMAX;
        if (nv < VMIN) nv = VMIN;
        m_reg[m_sel] = nv;
        m_dirty   = 1;
        m_last_ev = edge_no;
        m_have_ev = 1;
        if (m_editing != 0 && pb) fire = 1'b1;
        m_editing = 1;
      end else if (pb) begin
        if (m_editing != 0) fire = 1'b1;
        else m_sel = (m_sel + 1) % 4;
      end else if (m_editing != 0 && (edge_no - m_last_ev) == ITO) begin
        fire = 1'b1;
      end
      if (fire) begin
        m_wv = 1; m_wa = m_sel; m_wd = m_reg[m_sel];
      end
    end
  endtask

  task automatic cycle(input logic rst, ev, iz, pb, ack);
    RST = rst; EV = ev; IZ = iz; PB = pb; bus.WR_ACK = ack;
    @(posedge CLK);
    model_edge(rst, ev, iz, pb, ack);
    #1;
    RST = 1'b0; EV = 1'b0; IZ = 1'b0; PB = 1'b0; bus.WR_ACK = 1'b0;
  endtask

  function automatic logic [21:0] dut_vec();
    return {SEL, VAL, DIRTY, bus.WR_VALID, bus.WR_ADDR, bus.WR_DATA};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {2'(m_sel), W'(m_reg[m_sel]), 1'(m_dirty), 1'(m_wv), 2'(m_wa), W'(m_wd)};
  endfunction

  task automatic test_reset();
    logic [21:0] rst_vec;
    rst_vec = {2'd0, 8'd10, 1'b0, 1'b0, 2'd0, 8'd0};
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    n_total++;
    if (dut_vec() !== rst_vec) $display("FAIL reset_state got %h expected %h", dut_vec(), rst_vec);
    else n_pass++;
    $display("reset: SEL=%0d VAL=%0d DIRTY=%0b WR_VALID=%0b", SEL, VAL, DIRTY, bus.WR_VALID);
  endtask

  task automatic test_slow_steps();
    int exp_val [3] = '{11, 12, 13};
    for (int e = 0; e < 3; e++) begin
      if (e > 0) begin
        for (int j = 0; j < 9; j++) begin
          cycle(0, 0, 0, 0, 0);
          n_total++;
          if (dut_vec() !== exp_vec()) $display("FAIL slow_gap got %h expected %h", dut_vec(), exp_vec());
          else n_pass++;
        end
      end
      cycle(0, 1, 0, 0, 0);
      n_total++;
      if (VAL !== W'(exp_val[e]) || DIRTY !== 1'b1 || SEL !== 2'd0 || bus.WR_VALID !== 1'b0)
        $display("FAIL slow_step%0d got VAL=%0d DIRTY=%0b SEL=%0d WR_VALID=%0b expected VAL=%0d DIRTY=1 SEL=0 WR_VALID=0",
                 e, VAL, DIRTY, SEL, bus.WR_VALID, exp_val[e]);
      else n_pass++;
      $display("slow EV %0d: VAL=%0d", e, VAL);
    end
  endtask

  task automatic test_fast_saturation();
    int exp_dn [8] = '{42, 34, 26, 18, 10, 10, 10, 10};
    repeat (5) cycle(0, 0, 0, 0, 0);
    while (m_reg[0] < 45) begin
      cycle(0, 1, 0, 0, 0);
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL climb got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
      repeat (4) cycle(0, 0, 0, 0, 0);
    end
    cycle(0, 1, 0, 0, 0);
    n_total++;
    if (VAL !== 8'd46) $display("FAIL fast_first_slow got %0d expected 46", VAL);
    else n_pass++;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    n_total++;
    if (VAL !== 8'd50) $display("FAIL fast_clamp_max got %0d expected 50", VAL);
    else n_pass++;
    $display("fast up: VAL=%0d", VAL);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0);
      n_total++;
      if (VAL !== W'(exp_dn[i]) || dut_vec() !== exp_vec())
        $display("FAIL fast_down%0d got VAL=%0d vec=%h expected VAL=%0d vec=%h", i, VAL, dut_vec(), exp_dn[i], exp_vec());
      else n_pass++;
      $display("fast down %0d: VAL=%0d", i, VAL);
    end
  endtask

  task automatic test_timeout_commit();
    int k;
    logic [21:0] snap;
    k = 0;
    while (bus.WR_VALID !== 1'b1 && k < 40) begin
      cycle(0, 0, 0, 0, 0);
      k++;
    end
    n_total++;
    if (k != ITO) $display("FAIL timeout_latency got %0d cycles expected %0d", k, ITO);
    else n_pass++;
    n_total++;
    if (bus.WR_ADDR !== 2'd0 || bus.WR_DATA !== 8'd10 || VAL !== 8'd10)
      $display("FAIL timeout_payload got addr=%0d data=%0d VAL=%0d expected addr=0 data=10 VAL=10",
               bus.WR_ADDR, bus.WR_DATA, VAL);
    else n_pass++;
    $display("timeout commit: addr=%0d data=%0d after %0d cycles", bus.WR_ADDR, bus.WR_DATA, k);
    snap = dut_vec();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1'(i % 2), 1'($urandom_range(0, 1)), 1'(i == 2 || i == 4), 0);
      n_total++;
      if (dut_vec() !== snap || dut_vec() !== exp_vec())
        $display("FAIL commit_hold%0d got %h expected %h", i, dut_vec(), snap);
      else n_pass++;
    end
    cycle(0, 0, 0, 0, 1);
    n_total++;
    if (bus.WR_VALID !== 1'b0 || DIRTY !== 1'b0 || dut_vec() !== exp_vec())
      $display("FAIL commit_ack got WR_VALID=%0b DIRTY=%0b vec=%h expected WR_VALID=0 DIRTY=0 vec=%h",
               bus.WR_VALID, DIRTY, dut_vec(), exp_vec());
    else n_pass++;
    $display("ack: WR_VALID=%0b DIRTY=%0b", bus.WR_VALID, DIRTY);
  endtask

  task automatic test_select_commit();
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0, 1, 0);
      n_total++;
      if (SEL !== 2'(i) || VAL !== 8'd10)
        $display("FAIL select%0d got SEL=%0d VAL=%0d expected SEL=%0d VAL=10", i, SEL, VAL, i);
      else n_pass++;
      $display("select: SEL=%0d VAL=%0d", SEL, VAL);
    end
    cycle(0, 1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    n_total++;
    if (bus.WR_VALID !== 1'b1 || bus.WR_ADDR !== 2'd3 || bus.WR_DATA !== 8'd12)
      $display("FAIL forced_commit got valid=%0b addr=%0d data=%0d expected valid=1 addr=3 data=12",
               bus.WR_VALID, bus.WR_ADDR, bus.WR_DATA);
    else n_pass++;
    $display("forced commit: addr=%0d data=%0d", bus.WR_ADDR, bus.WR_DATA);
    cycle(0, 0, 0, 0, 1);
    n_total++;
    if (dut_vec() !== exp_vec()) $display("FAIL forced_ack got %h expected %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    repeat (5) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    n_total++;
    if (SEL !== 2'd3 || VAL !== 8'd13 || DIRTY !== 1'b1 || bus.WR_VALID !== 1'b0)
      $display("FAIL simultaneous got SEL=%0d VAL=%0d DIRTY=%0b valid=%0b expected SEL=3 VAL=13 DIRTY=1 valid=0",
               SEL, VAL, DIRTY, bus.WR_VALID);
    else n_pass++;
    $display("EV+PB in idle: SEL=%0d VAL=%0d", SEL, VAL);
  endtask

  task automatic test_reset_mid_commit();
    cycle(0, 0, 0, 1, 0);
    n_total++;
    if (bus.WR_VALID !== 1'b1) $display("FAIL enter_commit got valid=%0b expected 1", bus.WR_VALID);
    else n_pass++;
    cycle(1, 0, 0, 0, 0);
    n_total++;
    if (bus.WR_VALID !== 1'b0 || DIRTY !== 1'b0 || SEL !== 2'd0 || VAL !== 8'd10)
      $display("FAIL reset_mid_commit got valid=%0b DIRTY=%0b SEL=%0d VAL=%0d expected 0 0 0 10",
               bus.WR_VALID, DIRTY, SEL, VAL);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 1, 0);
      n_total++;
      if (SEL !== 2'(i % 4) || VAL !== 8'd10)
        $display("FAIL reset_regs%0d got SEL=%0d VAL=%0d expected SEL=%0d VAL=10", i, SEL, VAL, i % 4);
      else n_pass++;
    end
    $display("reset mid-commit: all registers at %0d", VAL);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 40);
      n_total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        if (bad <= 10) $display("FAIL random cycle %0d got %h expected %h", i, dut_vec(), exp_vec());
      end else n_pass++;
    end
    $display("random: 600 cycles, %0d differences", bad);
  endtask

  initial begin
    bus.WR_ACK = 1'b0;
    test_reset();
    test_slow_steps();
    test_fast_saturation();
    test_timeout_commit();
    test_select_commit();
    test_simultaneous();
    test_reset_mid_commit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
